// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch resolution, redirect/flush sequencing and 2-bit counter predictor
module branch_ctrl #(
  parameter int         XLEN         = 32,
  parameter int         BHT_ENTRIES  = 16,
  parameter int         FLUSH_CYCLES = 2,
  parameter logic [1:0] RESET_CTR    = 2'b01
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] f_pc,
  output logic            f_pred_taken,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic            ex_je,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic [31:0]     mispredict_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e            state_q, state_d;
  logic [FC_W-1:0]   flush_ctr_q, flush_ctr_d;
  logic              redirect_q, redirect_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic [31:0]       mispredict_count_q, mispredict_count_d;
  logic [1:0]        bht_q [BHT_ENTRIES];

  logic [IDX_W-1:0]  lk_idx, up_idx;
  logic              resolve, bht_we, need_redirect;
  logic [1:0]        ctr_old, ctr_new;
  logic              unused_pc_bits;

  assign lk_idx         = f_pc[IDX_W+1:2];
  assign up_idx         = ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{f_pc[XLEN-1:IDX_W+2], f_pc[1:0]};
  // Lookup reads the registered table, so a same-index update is seen next cycle.
  assign f_pred_taken   = bht_q[lk_idx][1];

  always_comb begin
    resolve       = ex_valid && !stall && (state_q == IDLE);
    bht_we        = resolve && ex_branch && !ex_jump;
    need_redirect = resolve && (ex_jump || (ex_branch && (ex_je != ex_pred_taken)));
    ctr_old       = bht_q[up_idx];
    ctr_new       = ctr_old;
    if (ex_je && (ctr_old != 2'b11)) begin
      ctr_new = ctr_old + 2'b01;
    end else if (!ex_je && (ctr_old != 2'b00)) begin
      ctr_new = ctr_old - 2'b01;
    end
  end

  always_comb begin
    state_d            = state_q;
    flush_ctr_d        = flush_ctr_q;
    redirect_d         = 1'b0;
    redirect_pc_d      = redirect_pc_q;
    mispredict_count_d = mispredict_count_q;
    case (state_q)
      IDLE: begin
        if (need_redirect) begin
          state_d       = FLUSH;
          flush_ctr_d   = FC_LOAD;
          redirect_d    = 1'b1;
          redirect_pc_d = (ex_jump || ex_je) ? ex_target : ex_pc + XLEN'(4);
          if (mispredict_count_q != 32'hFFFF_FFFF) begin
            mispredict_count_d = mispredict_count_q + 32'd1;
          end
        end
      end
      FLUSH: begin
        if (flush_ctr_q == '0) begin
          state_d = IDLE;
        end else begin
          flush_ctr_d = flush_ctr_q - FC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= IDLE;
      flush_ctr_q        <= '0;
      redirect_q         <= 1'b0;
      redirect_pc_q      <= '0;
      mispredict_count_q <= '0;
    end else begin
      state_q            <= state_d;
      flush_ctr_q        <= flush_ctr_d;
      redirect_q         <= redirect_d;
      redirect_pc_q      <= redirect_pc_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= RESET_CTR;
      end
    end else if (bht_we) begin
      bht_q[up_idx] <= ctr_new;
    end
  end

  assign redirect         = redirect_q;
  assign redirect_pc      = redirect_pc_q;
  assign flush            = (state_q == FLUSH);
  assign mispredict_count = mispredict_count_q;

endmodule
